// File: rtl/if_stage_if.sv
// Instruction-memory request/grant/response bundle between the fetch stage
// (master) and instruction memory (slave).
interface if_stage_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_gnt_i,
      input  imem_rvalid_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_gnt_i,
      output imem_rvalid_i,
      output imem_rdata_i
   );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps up to two requests in flight,
// tags returned words with their address in a 2-entry buffer for decode, and
// discards stale responses after a redirect.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold_i,
   input  logic              jump_i,
   input  logic [31:0]       jump_addr_i,
   if_stage_if.master        imem,
   output logic              inst_valid_o,
   output logic [31:0]       inst_o,
   output logic [31:0]       inst_addr_o
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] pc_q, pc_d;
   logic [1:0]  out_q, out_d;
   logic [1:0]  disc_q, disc_d;
   logic [31:0] afifo_q [2];
   logic [31:0] afifo_d [2];
   logic        a_wr_q, a_wr_d, a_rd_q, a_rd_d;
   logic [31:0] baddr_q [2];
   logic [31:0] baddr_d [2];
   logic [31:0] binst_q [2];
   logic [31:0] binst_d [2];
   logic        b_wr_q, b_wr_d, b_rd_q, b_rd_d;
   logic [1:0]  cnt_q, cnt_d;

   logic        pop, req, gnt, rsp, push;
   logic [2:0]  credit;

   assign inst_valid_o     = (cnt_q != 2'd0);
   assign inst_o           = inst_valid_o ? binst_q[b_rd_q] : NOP;
   assign inst_addr_o      = inst_valid_o ? baddr_q[b_rd_q] : '0;
   assign imem.imem_req_o  = req;
   assign imem.imem_addr_o = pc_q;

   // Handshake decode, credit rule and next-state for PC, in-flight tracking and buffer.
   always_comb begin
      pop      = inst_valid_o & ~hold_i & ~jump_i;
      // Requests in flight plus buffered words, after this cycle's pop, may not exceed two.
      credit   = 3'(out_q) + 3'(cnt_q) - 3'(pop);
      req      = ~rst & ~jump_i & (credit < 3'd2);
      gnt      = req & imem.imem_gnt_i;
      // A response with nothing outstanding is a protocol error and is ignored.
      rsp      = imem.imem_rvalid_i & (out_q != 2'd0);
      push     = rsp & (disc_q == 2'd0) & ~jump_i;

      pc_d     = pc_q;
      afifo_d  = afifo_q;
      a_wr_d   = a_wr_q;
      a_rd_d   = a_rd_q;
      out_d    = out_q + 2'(gnt) - 2'(rsp);
      disc_d   = disc_q;
      baddr_d  = baddr_q;
      binst_d  = binst_q;
      b_wr_d   = b_wr_q;
      b_rd_d   = b_rd_q;
      cnt_d    = cnt_q;

      if (gnt) begin
         afifo_d[a_wr_q] = pc_q;
         a_wr_d          = ~a_wr_q;
         pc_d            = pc_q + 32'd4;
      end
      if (rsp) begin
         a_rd_d = ~a_rd_q;
      end

      if (jump_i) begin
         pc_d   = {jump_addr_i[31:2], 2'b00};
         // Every request still unanswered after this cycle belongs to the old path.
         disc_d = out_q - 2'(rsp);
         cnt_d  = '0;
         b_wr_d = 1'b0;
         b_rd_d = 1'b0;
      end else begin
         if (rsp && disc_q != 2'd0) begin
            disc_d = disc_q - 2'd1;
         end
         if (push) begin
            baddr_d[b_wr_q] = afifo_q[a_rd_q];
            binst_d[b_wr_q] = imem.imem_rdata_i;
            b_wr_d          = ~b_wr_q;
         end
         if (pop) begin
            b_rd_d = ~b_rd_q;
         end
         cnt_d = cnt_q + 2'(push) - 2'(pop);
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         out_q   <= '0;
         disc_q  <= '0;
         afifo_q <= '{default: '0};
         a_wr_q  <= 1'b0;
         a_rd_q  <= 1'b0;
         baddr_q <= '{default: '0};
         binst_q <= '{default: '0};
         b_wr_q  <= 1'b0;
         b_rd_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         out_q   <= out_d;
         disc_q  <= disc_d;
         afifo_q <= afifo_d;
         a_wr_q  <= a_wr_d;
         a_rd_q  <= a_rd_d;
         baddr_q <= baddr_d;
         binst_q <= binst_d;
         b_wr_q  <= b_wr_d;
         b_rd_q  <= b_rd_d;
         cnt_q   <= cnt_d;
      end
   end

   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
      !(imem.imem_rvalid_i && out_q == 2'd0));

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a memory model answers grants after a
// configurable latency, expected fetch addresses go into a scoreboard queue
// when granted, and a monitor checks every word handed to decode.
module tb_if_stage;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hold = 1'b0;
   logic        jump = 1'b0;
   logic [31:0] jaddr = '0;
   logic        inst_valid;
   logic [31:0] inst, inst_addr;

   if_stage_if bus();

   if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .hold_i       (hold),
      .jump_i       (jump),
      .jump_addr_i  (jaddr),
      .imem         (bus.master),
      .inst_valid_o (inst_valid),
      .inst_o       (inst),
      .inst_addr_o  (inst_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mem_t;

   int          errors = 0;
   int          checks = 0;
   int          nhand = 0;
   int          cyc = 0;
   int          lat = 1;
   int          nh0, nh1, nh2;
   logic        gnt_v = 1'b1;
   logic [31:0] exp_fetch = '0;
   logic [31:0] expq [$];
   mem_t        memq [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Drive memory side for the current cycle, then account for a grant.
   task automatic pre();
      mem_t m;
      if (rst) begin
         bus.imem_gnt_i    = 1'($urandom);
         bus.imem_rvalid_i = 1'($urandom);
         bus.imem_rdata_i  = $urandom;
      end else begin
         bus.imem_gnt_i = gnt_v;
         if (memq.size() > 0 && memq[0].due == cyc) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = memq[0].addr ^ KEY;
         end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = $urandom;
         end
      end
      #1;
      if (!rst) begin
         if (jump) begin
            chk("req_in_jump", 32'(bus.imem_req_o), 32'd0);
            expq.delete();
         end
         if (bus.imem_req_o && bus.imem_gnt_i) begin
            chk("grant_addr", bus.imem_addr_o, exp_fetch);
            expq.push_back(exp_fetch);
            m.addr = exp_fetch;
            m.due  = cyc + lat;
            memq.push_back(m);
            exp_fetch = exp_fetch + 32'd4;
         end
         if (jump) exp_fetch = {jaddr[31:2], 2'b00};
      end
   endtask

   task automatic post();
      @(posedge clk);
      if (!rst && bus.imem_rvalid_i && memq.size() > 0) memq.delete(0);
      cyc++;
      @(negedge clk);
   endtask

   task automatic step();
      pre();
      post();
   endtask

   // Monitor: every handover to decode must match the scoreboard head.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         #3;
         if (!rst) begin
            if (inst_valid && !hold && !jump) begin
               nhand++;
               if (expq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL hand_unexpected: got addr %h want none", inst_addr);
               end else begin
                  e = expq.pop_front();
                  chk("hand_addr", inst_addr, e);
                  chk("hand_data", inst, e ^ KEY);
               end
            end else if (!inst_valid) begin
               chk("idle_inst", inst, 32'h0000_0013);
               chk("idle_addr", inst_addr, 32'd0);
            end
         end
      end
   end

   initial begin
      @(negedge clk);
      // Reset with random inputs
      for (int i = 0; i < 3; i++) begin
         hold  = 1'($urandom);
         jump  = 1'($urandom);
         jaddr = $urandom;
         pre();
         chk("rst_req", 32'(bus.imem_req_o), 32'd0);
         chk("rst_valid", 32'(inst_valid), 32'd0);
         chk("rst_inst", inst, 32'h0000_0013);
         chk("rst_iaddr", inst_addr, 32'd0);
         chk("rst_fetch_addr", bus.imem_addr_o, 32'd0);
         post();
      end
      rst = 1'b0; hold = 1'b0; jump = 1'b0; jaddr = '0;
      cyc = 0; lat = 1; gnt_v = 1'b1; exp_fetch = '0;

      // Streaming, 1-cycle memory
      pre();
      chk("first_req", 32'(bus.imem_req_o), 32'd1);
      chk("first_addr", bus.imem_addr_o, 32'd0);
      post();
      step();
      pre();
      chk("lat_valid", 32'(inst_valid), 32'd1);
      chk("lat_addr", inst_addr, 32'd0);
      post();
      for (int i = 3; i < 10; i++) step();

      // Hold for three cycles
      hold = 1'b1;
      for (int i = 10; i < 13; i++) begin
         pre();
         chk("hold_frozen", inst_addr, 32'h20);
         chk("hold_req", 32'(bus.imem_req_o), 32'd0);
         post();
      end
      hold = 1'b0;
      pre();
      chk("release_req", 32'(bus.imem_req_o), 32'd1);
      chk("release_fetch", bus.imem_addr_o, 32'h28);
      post();
      for (int i = 14; i < 18; i++) step();
      chk("stream_count", 32'(nhand), 32'd13);

      // Reset mid-operation
      rst = 1'b1;
      memq.delete();
      expq.delete();
      pre();
      chk("midrst_valid", 32'(inst_valid), 32'd0);
      chk("midrst_req", 32'(bus.imem_req_o), 32'd0);
      chk("midrst_fetch", bus.imem_addr_o, 32'd0);
      post();
      step();
      rst = 1'b0; hold = 1'b0; jump = 1'b0;
      cyc = 0; lat = 2; gnt_v = 1'b1; exp_fetch = '0;
      nh0 = nhand;

      // Jump with 0x10 and 0x14 in flight, 2-cycle memory
      for (int i = 0; i < 8; i++) step();
      chk("prejump_count", 32'(nhand - nh0), 32'd4);
      jump = 1'b1; jaddr = 32'h0000_0103;
      step();
      jump = 1'b0;
      pre();
      chk("jump_fetch", bus.imem_addr_o, 32'h100);
      chk("jump_req", 32'(bus.imem_req_o), 32'd1);
      chk("jump_flush", 32'(inst_valid), 32'd0);
      post();
      for (int i = 10; i < 12; i++) begin
         pre();
         chk("jump_wait", 32'(inst_valid), 32'd0);
         post();
      end
      pre();
      chk("jump_first_valid", 32'(inst_valid), 32'd1);
      chk("jump_first_addr", inst_addr, 32'h100);
      post();

      // Jump while holding a full buffer
      hold = 1'b1;
      for (int i = 13; i < 15; i++) begin
         pre();
         chk("jh_req", 32'(bus.imem_req_o), 32'd0);
         post();
      end
      jump = 1'b1; jaddr = 32'h0000_0200;
      pre();
      chk("jh_head", inst_addr, 32'h104);
      post();
      jump = 1'b0; hold = 1'b0; lat = 1;
      nh1 = nhand;

      // Toggling grant
      for (int i = 16; i < 30; i++) begin
         gnt_v = (cyc % 2) == 1;
         pre();
         if (i == 16) begin
            chk("jh_flushed", 32'(inst_valid), 32'd0);
            chk("jh_pc", bus.imem_addr_o, 32'h200);
         end
         post();
      end
      chk("toggle_count", 32'(nhand - nh1 >= 4), 32'd1);

      // Wrap from the top of the address space
      gnt_v = 1'b0; jump = 1'b1; jaddr = 32'hFFFF_FFFF;
      step();
      jump = 1'b0;
      nh2 = nhand;
      gnt_v = 1'b1;
      pre();
      chk("wrap_pc", bus.imem_addr_o, 32'hFFFF_FFFC);
      post();
      gnt_v = 1'b0;
      pre();
      chk("wrap_next", bus.imem_addr_o, 32'h0);
      post();
      for (int i = 33; i < 46; i++) begin
         gnt_v = (cyc % 2) == 1;
         step();
      end
      gnt_v = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("wrap_count", 32'(nhand - nh2 >= 5), 32'd1);
      chk("drain_empty", 32'(expq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
